// File: rtl/idex_stage_reg_pkg.sv
// Shared encodings, defaults and small helpers for the ID/EX stage register.
package idex_stage_reg_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CTRL_W_DEF = 16;

  localparam logic [5:0] OP_RTYPE   = 6'b000000;
  localparam logic [5:0] FUNCT_JR   = 6'b001000;
  localparam logic [5:0] FUNCT_JALR = 6'b001001;

  typedef enum logic [1:0] {
    MTR_ALU  = 2'b00,
    MTR_MEM  = 2'b01,
    MTR_LINK = 2'b10
  } memtoReg_e;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } mode_e;

  // Narrow, fixed-width part of the ID/EX register; wide data fields live beside it.
  typedef struct packed {
    logic       valid;
    logic [5:0] opCode;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       usesRt;
    logic       regWr;
    logic [4:0] regWrAddr;
    logic       memRead;
    logic       memWr;
    logic [1:0] memtoReg;
  } idexCtl_t;

  function automatic logic [31:0] satInc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/idex_stage_reg_load_use_detect.sv
// Load-use / jr-after-load hazard detector: returns bubbles needed (0..2) for the ID instruction.
module load_use_detect
  import idex_stage_reg_pkg::*;
(
  input  logic       en,
  input  logic       idValid,
  input  logic [5:0] idOpCode,
  input  logic [5:0] idFunct,
  input  logic [4:0] idRs,
  input  logic [4:0] idRt,
  input  logic       idUsesRt,
  input  logic       exMemRead,
  input  logic [4:0] exRegWrAddr,
  input  logic       memMemRead,
  input  logic [4:0] memRegWrAddr,
  output logic [1:0] need
);

  logic isJr, exHitRs, exHitRt, memHitRs, loadUse;

  assign isJr     = (idOpCode == OP_RTYPE) && (idFunct == FUNCT_JR || idFunct == FUNCT_JALR);
  assign exHitRs  = exMemRead && (exRegWrAddr != 5'd0) && (exRegWrAddr == idRs);
  assign exHitRt  = exMemRead && (exRegWrAddr != 5'd0) && (exRegWrAddr == idRt) && idUsesRt;
  assign memHitRs = memMemRead && (memRegWrAddr != 5'd0) && (memRegWrAddr == idRs);
  // A store matching only on rt has idUsesRt=0; its data is forwarded later instead.
  assign loadUse  = exHitRs || exHitRt;

  always_comb begin
    need = 2'd0;
    if (en && idValid) begin
      if (loadUse) need = 2'd1;
      // jr resolves its target in ID, so a load still in EX costs an extra slot.
      if (isJr) begin
        if (exHitRs)       need = 2'd2;
        else if (memHitRs) need = 2'd1;
      end
    end
  end

endmodule

// File: rtl/idex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion and front-end hold.
module idex_stage_reg
  import idex_stage_reg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ID_Valid,
  input  logic [5:0]        ID_OpCode,
  input  logic [5:0]        ID_Funct,
  input  logic [4:0]        ID_Rs,
  input  logic [4:0]        ID_Rt,
  input  logic              ID_UsesRt,
  input  logic              ID_RegWr,
  input  logic [4:0]        ID_RegWrAddr,
  input  logic              ID_MemRead,
  input  logic              ID_MemWr,
  input  logic [1:0]        ID_MemtoReg,
  input  logic [CTRL_W-1:0] ID_Ctrl,
  input  logic [DATA_W-1:0] ID_PC,
  input  logic [DATA_W-1:0] ID_RsData,
  input  logic [DATA_W-1:0] ID_RtData,
  input  logic [DATA_W-1:0] ID_Imm,
  input  logic              EXMEM_MemRead,
  input  logic [4:0]        EXMEM_RegWrAddr,
  input  logic              Stall_In,
  input  logic              Flush,
  output logic              IDEX_Valid,
  output logic [5:0]        IDEX_OpCode,
  output logic [5:0]        IDEX_Funct,
  output logic [4:0]        IDEX_Rs,
  output logic [4:0]        IDEX_Rt,
  output logic              IDEX_UsesRt,
  output logic              IDEX_RegWr,
  output logic [4:0]        IDEX_RegWrAddr,
  output logic              IDEX_MemRead,
  output logic              IDEX_MemWr,
  output logic [1:0]        IDEX_MemtoReg,
  output logic [CTRL_W-1:0] IDEX_Ctrl,
  output logic [DATA_W-1:0] IDEX_PC,
  output logic [DATA_W-1:0] IDEX_RsData,
  output logic [DATA_W-1:0] IDEX_RtData,
  output logic [DATA_W-1:0] IDEX_Imm,
  output logic              Stall_Front,
  output logic [31:0]       Bubble_Cnt
);

  idexCtl_t          ctlQ, ctlNxt, ctlId;
  logic [CTRL_W-1:0] ctrlQ, ctrlNxt;
  logic [DATA_W-1:0] pcQ, pcNxt, rsDQ, rsDNxt, rtDQ, rtDNxt, immQ, immNxt;
  logic [1:0]        cnt, cntNxt, need;
  logic [31:0]       bubbleCnt, bubbleCntNxt;
  mode_e             mode;

  assign mode = (cnt != 2'd0) ? STALL : RUN;

  load_use_detect uDetect (
    .en           (mode == RUN),
    .idValid      (ID_Valid),
    .idOpCode     (ID_OpCode),
    .idFunct      (ID_Funct),
    .idRs         (ID_Rs),
    .idRt         (ID_Rt),
    .idUsesRt     (ID_UsesRt),
    .exMemRead    (ctlQ.memRead),
    .exRegWrAddr  (ctlQ.regWrAddr),
    .memMemRead   (EXMEM_MemRead),
    .memRegWrAddr (EXMEM_RegWrAddr),
    .need         (need)
  );

  assign Stall_Front = Stall_In || (mode == STALL) || (need != 2'd0);

  assign ctlId = '{valid: ID_Valid, opCode: ID_OpCode, funct: ID_Funct, rs: ID_Rs,
                   rt: ID_Rt, usesRt: ID_UsesRt, regWr: ID_RegWr, regWrAddr: ID_RegWrAddr,
                   memRead: ID_MemRead, memWr: ID_MemWr, memtoReg: ID_MemtoReg};

  always_comb begin
    ctlNxt       = ctlQ;
    ctrlNxt      = ctrlQ;
    pcNxt        = pcQ;
    rsDNxt       = rsDQ;
    rtDNxt       = rtDQ;
    immNxt       = immQ;
    cntNxt       = cnt;
    bubbleCntNxt = bubbleCnt;
    if (Flush) begin
      ctlNxt = '0; ctrlNxt = '0; pcNxt = '0; rsDNxt = '0; rtDNxt = '0; immNxt = '0;
      cntNxt = 2'd0;
    end else if (Stall_In) begin
      cntNxt = cnt;
    end else if (mode == STALL || need != 2'd0) begin
      ctlNxt = '0; ctrlNxt = '0; pcNxt = '0; rsDNxt = '0; rtDNxt = '0; immNxt = '0;
      cntNxt       = (mode == STALL) ? cnt - 2'd1 : need - 2'd1;
      bubbleCntNxt = satInc32(bubbleCnt);
    end else begin
      ctlNxt = ctlId; ctrlNxt = ID_Ctrl; pcNxt = ID_PC;
      rsDNxt = ID_RsData; rtDNxt = ID_RtData; immNxt = ID_Imm;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctlQ      <= '0;
      ctrlQ     <= '0;
      pcQ       <= '0;
      rsDQ      <= '0;
      rtDQ      <= '0;
      immQ      <= '0;
      cnt       <= 2'd0;
      bubbleCnt <= 32'd0;
    end else begin
      ctlQ      <= ctlNxt;
      ctrlQ     <= ctrlNxt;
      pcQ       <= pcNxt;
      rsDQ      <= rsDNxt;
      rtDQ      <= rtDNxt;
      immQ      <= immNxt;
      cnt       <= cntNxt;
      bubbleCnt <= bubbleCntNxt;
    end
  end

  assign IDEX_Valid     = ctlQ.valid;
  assign IDEX_OpCode    = ctlQ.opCode;
  assign IDEX_Funct     = ctlQ.funct;
  assign IDEX_Rs        = ctlQ.rs;
  assign IDEX_Rt        = ctlQ.rt;
  assign IDEX_UsesRt    = ctlQ.usesRt;
  assign IDEX_RegWr     = ctlQ.regWr;
  assign IDEX_RegWrAddr = ctlQ.regWrAddr;
  assign IDEX_MemRead   = ctlQ.memRead;
  assign IDEX_MemWr     = ctlQ.memWr;
  assign IDEX_MemtoReg  = ctlQ.memtoReg;
  assign IDEX_Ctrl      = ctrlQ;
  assign IDEX_PC        = pcQ;
  assign IDEX_RsData    = rsDQ;
  assign IDEX_RtData    = rtDQ;
  assign IDEX_Imm       = immQ;
  assign Bubble_Cnt     = bubbleCnt;

endmodule

// File: tb/tb_idex_stage_reg.sv
// Directed bench for idex_stage_reg: load-use, jr/jalr stalls, flush, hold and reset.
module tb_idex_stage_reg;
  import idex_stage_reg_pkg::*;

  logic        clk = 1'b0, reset;
  logic        ID_Valid, ID_UsesRt, ID_RegWr, ID_MemRead, ID_MemWr;
  logic [5:0]  ID_OpCode, ID_Funct;
  logic [4:0]  ID_Rs, ID_Rt, ID_RegWrAddr;
  logic [1:0]  ID_MemtoReg;
  logic [15:0] ID_Ctrl;
  logic [31:0] ID_PC, ID_RsData, ID_RtData, ID_Imm;
  logic        EXMEM_MemRead, Stall_In, Flush;
  logic [4:0]  EXMEM_RegWrAddr;
  logic        IDEX_Valid, IDEX_UsesRt, IDEX_RegWr, IDEX_MemRead, IDEX_MemWr;
  logic [5:0]  IDEX_OpCode, IDEX_Funct;
  logic [4:0]  IDEX_Rs, IDEX_Rt, IDEX_RegWrAddr;
  logic [1:0]  IDEX_MemtoReg;
  logic [15:0] IDEX_Ctrl;
  logic [31:0] IDEX_PC, IDEX_RsData, IDEX_RtData, IDEX_Imm, Bubble_Cnt;
  logic        Stall_Front;

  int nChecks = 0, nErrors = 0;

  idex_stage_reg dut (
    .clk(clk), .reset(reset),
    .ID_Valid(ID_Valid), .ID_OpCode(ID_OpCode), .ID_Funct(ID_Funct), .ID_Rs(ID_Rs),
    .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt), .ID_RegWr(ID_RegWr), .ID_RegWrAddr(ID_RegWrAddr),
    .ID_MemRead(ID_MemRead), .ID_MemWr(ID_MemWr), .ID_MemtoReg(ID_MemtoReg),
    .ID_Ctrl(ID_Ctrl), .ID_PC(ID_PC), .ID_RsData(ID_RsData), .ID_RtData(ID_RtData),
    .ID_Imm(ID_Imm), .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_RegWrAddr(EXMEM_RegWrAddr),
    .Stall_In(Stall_In), .Flush(Flush),
    .IDEX_Valid(IDEX_Valid), .IDEX_OpCode(IDEX_OpCode), .IDEX_Funct(IDEX_Funct),
    .IDEX_Rs(IDEX_Rs), .IDEX_Rt(IDEX_Rt), .IDEX_UsesRt(IDEX_UsesRt), .IDEX_RegWr(IDEX_RegWr),
    .IDEX_RegWrAddr(IDEX_RegWrAddr), .IDEX_MemRead(IDEX_MemRead), .IDEX_MemWr(IDEX_MemWr),
    .IDEX_MemtoReg(IDEX_MemtoReg), .IDEX_Ctrl(IDEX_Ctrl), .IDEX_PC(IDEX_PC),
    .IDEX_RsData(IDEX_RsData), .IDEX_RtData(IDEX_RtData), .IDEX_Imm(IDEX_Imm),
    .Stall_Front(Stall_Front), .Bubble_Cnt(Bubble_Cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Data fields are derived from the PC so captured values are checkable.
  task automatic setId(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
                       input logic regWr, input logic [4:0] wrAddr, input logic memRead,
                       input logic memWr, input logic [1:0] mtr, input logic [31:0] pc);
    ID_Valid = v; ID_OpCode = op; ID_Funct = fn; ID_Rs = rs; ID_Rt = rt;
    ID_UsesRt = usesRt; ID_RegWr = regWr; ID_RegWrAddr = wrAddr; ID_MemRead = memRead;
    ID_MemWr = memWr; ID_MemtoReg = mtr; ID_PC = pc;
    ID_Ctrl = pc[15:0] ^ 16'h1234; ID_RsData = pc ^ 32'hA5A5_0000;
    ID_RtData = pc ^ 32'h0000_5A5A; ID_Imm = pc + 32'd4;
    #1;
  endtask

  task automatic idLw(input logic [4:0] dst, input logic [31:0] pc);
    setId(1, 6'h23, 6'h00, 5'd3, dst, 0, 1, dst, 1, 0, MTR_MEM, pc);
  endtask

  task automatic idJr(input logic [4:0] rs, input logic [31:0] pc);
    setId(1, OP_RTYPE, FUNCT_JR, rs, 5'd0, 0, 0, 5'd0, 0, 0, MTR_ALU, pc);
  endtask

  task automatic idAdd(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [31:0] pc);
    setId(1, OP_RTYPE, 6'h20, rs, rt, 1, 1, rd, 0, 0, MTR_ALU, pc);
  endtask

  initial begin
    reset = 1; Stall_In = 0; Flush = 0; EXMEM_MemRead = 0; EXMEM_RegWrAddr = 0;
    setId(1, 6'h23, 6'h00, 5'd1, 5'd2, 0, 1, 5'd2, 1, 0, MTR_MEM, 32'h40);
    tick(); tick();
    chk("rst_valid", IDEX_Valid, 0);
    chk("rst_memrd", IDEX_MemRead, 0);
    chk("rst_pc", IDEX_PC, 0);
    chk("rst_bcnt", Bubble_Cnt, 0);
    reset = 0;

    // 1: load-use on rs
    idLw(5'd8, 32'h1000); tick();
    chk("s1_lw_memrd", IDEX_MemRead, 1);
    chk("s1_lw_wraddr", IDEX_RegWrAddr, 8);
    idAdd(5'd9, 5'd8, 5'd2, 32'h1004);
    chk("s1_stall", Stall_Front, 1);
    tick();
    chk("s1_bub_valid", IDEX_Valid, 0);
    chk("s1_bub_pc", IDEX_PC, 0);
    chk("s1_bub_ctrl", IDEX_Ctrl, 0);
    chk("s1_bcnt", Bubble_Cnt, 1);
    chk("s1_stall_rel", Stall_Front, 0);
    tick();
    chk("s1_add_valid", IDEX_Valid, 1);
    chk("s1_add_wraddr", IDEX_RegWrAddr, 9);
    chk("s1_add_pc", IDEX_PC, 32'h1004);
    chk("s1_add_rsd", IDEX_RsData, 32'h1004 ^ 32'hA5A5_0000);
    chk("s1_add_ctrl", IDEX_Ctrl, 32'h1004 ^ 32'h1234);

    // 2: store matching only on rt does not stall
    idLw(5'd8, 32'h1008); tick();
    setId(1, 6'h2b, 6'h00, 5'd3, 5'd8, 0, 0, 5'd0, 0, 1, MTR_ALU, 32'h100C);
    chk("s2_nostall", Stall_Front, 0);
    tick();
    chk("s2_sw_memwr", IDEX_MemWr, 1);
    chk("s2_sw_pc", IDEX_PC, 32'h100C);
    chk("s2_bcnt", Bubble_Cnt, 1);

    // 3: jr right after load -> 2 bubbles
    idLw(5'd31, 32'h2000); tick();
    idJr(5'd31, 32'h2004);
    chk("s3_stall0", Stall_Front, 1);
    tick();
    chk("s3_bub1", IDEX_Valid, 0);
    chk("s3_stall1", Stall_Front, 1);
    tick();
    chk("s3_bub2", IDEX_Valid, 0);
    chk("s3_bcnt", Bubble_Cnt, 3);
    chk("s3_stall2", Stall_Front, 0);
    tick();
    chk("s3_jr_valid", IDEX_Valid, 1);
    chk("s3_jr_funct", IDEX_Funct, FUNCT_JR);
    chk("s3_jr_rs", IDEX_Rs, 31);

    // 4: jalr one slot after load -> 1 bubble
    EXMEM_MemRead = 1; EXMEM_RegWrAddr = 5'd4;
    setId(1, OP_RTYPE, FUNCT_JALR, 5'd4, 5'd0, 0, 1, 5'd31, 0, 0, MTR_LINK, 32'h3000);
    chk("s4_stall", Stall_Front, 1);
    tick();
    chk("s4_bub", IDEX_Valid, 0);
    chk("s4_bcnt", Bubble_Cnt, 4);
    EXMEM_MemRead = 0; EXMEM_RegWrAddr = 0; #1;
    chk("s4_stall_rel", Stall_Front, 0);
    tick();
    chk("s4_jalr_mtr", IDEX_MemtoReg, MTR_LINK);
    chk("s4_jalr_pc", IDEX_PC, 32'h3000);
    idLw(5'd4, 32'h3004); tick();
    idAdd(5'd5, 5'd0, 5'd0, 32'h3008);
    chk("s4_r0_nostall", Stall_Front, 0);
    tick();
    chk("s4_add_wraddr", IDEX_RegWrAddr, 5);
    chk("s4_bcnt2", Bubble_Cnt, 4);

    // 5: flush in first bubble of a jr stall, then external hold
    idLw(5'd31, 32'h4000); tick();
    idJr(5'd31, 32'h4004); tick();
    chk("s5_bcnt", Bubble_Cnt, 5);
    Flush = 1; #1;
    tick();
    Flush = 0; #1;
    chk("s5_fl_valid", IDEX_Valid, 0);
    chk("s5_fl_stall", Stall_Front, 0);
    chk("s5_fl_bcnt", Bubble_Cnt, 5);
    idAdd(5'd9, 5'd8, 5'd2, 32'h0100); tick();
    chk("s5_add_pc", IDEX_PC, 32'h0100);
    Stall_In = 1;
    idAdd(5'd10, 5'd11, 5'd12, 32'h0104);
    chk("s5_hold_stall", Stall_Front, 1);
    for (int i = 0; i < 3; i++) tick();
    chk("s5_hold_pc", IDEX_PC, 32'h0100);
    chk("s5_hold_wraddr", IDEX_RegWrAddr, 9);
    chk("s5_hold_bcnt", Bubble_Cnt, 5);
    Stall_In = 0; #1;
    tick();
    chk("s5_rel_pc", IDEX_PC, 32'h0104);
    Stall_In = 1; Flush = 1; #1;
    tick();
    Stall_In = 0; Flush = 0;
    chk("s5_flush_over_hold", IDEX_Valid, 0);

    // 6: reset during cnt=1
    idLw(5'd31, 32'h5000); tick();
    idJr(5'd31, 32'h5004); tick();
    chk("s6_bcnt", Bubble_Cnt, 6);
    reset = 1; #1;
    tick();
    reset = 0;
    chk("s6_rst_valid", IDEX_Valid, 0);
    chk("s6_rst_bcnt", Bubble_Cnt, 0);
    idAdd(5'd7, 5'd1, 5'd2, 32'h0200);
    chk("s6_run_stall", Stall_Front, 0);
    tick();
    chk("s6_cap_valid", IDEX_Valid, 1);
    chk("s6_cap_pc", IDEX_PC, 32'h0200);
    chk("s6_cap_bcnt", Bubble_Cnt, 0);

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/idex_stage_reg.md
Name: idex_stage_reg

Overview:
ID/EX pipeline register with integrated load-use hazard control for the 5-stage MIPS core, which has no delay slot. Each cycle it captures the decoded instruction from ID. When a load result cannot be forwarded in time, it inserts bubbles and holds the front end. Its registered outputs feed the EX datapath and the RAW/SAL forwarding logic. It also takes EX/MEM fields so it can extend jr/jalr stalls.

Parameters:
DATA_W, 32, width of PC, register operands and immediate
CTRL_W, 16, opaque EX/MEM control bundle (ALUOp, ALUSrc, branch bits); passed through unchanged

Ports:
clk  in  1  core clock, rising edge
reset  in  1  synchronous, active-high
ID_Valid  in  1  ID holds a real instruction
ID_OpCode  in  6  opcode of ID instruction
ID_Funct  in  6  funct of ID instruction
ID_Rs  in  5  source register rs
ID_Rt  in  5  source register rt
ID_UsesRt  in  1  ID instruction reads rt as ALU operand (R-type, beq/bne)
ID_RegWr  in  1  register-write enable
ID_RegWrAddr  in  5  destination register
ID_MemRead  in  1  load
ID_MemWr  in  1  store
ID_MemtoReg  in  2  writeback select (2'b10 = PC+4 link)
ID_Ctrl  in  CTRL_W  pass-through control
ID_PC  in  DATA_W  instruction PC
ID_RsData  in  DATA_W  register-file rs value
ID_RtData  in  DATA_W  register-file rt value
ID_Imm  in  DATA_W  extended immediate
EXMEM_MemRead  in  1  load currently in MEM
EXMEM_RegWrAddr  in  5  its destination
Stall_In  in  1  global hold from memory side
Flush  in  1  EX branch/jump redirect; squashes ID
IDEX_*  out  (same widths as ID_* above, plus IDEX_Valid)  registered copies
Stall_Front  out  1  hold PC and IF/ID (combinational)
Bubble_Cnt  out  32  saturating count of hazard bubbles inserted

Behaviour:
- Reset applies on the clock edge. All IDEX_* outputs go to 0 (a bubble), the counter cnt goes to 0, and Bubble_Cnt goes to 0.
- Bubble: IDEX_Valid, IDEX_RegWr, IDEX_MemRead, IDEX_MemWr, IDEX_MemtoReg and IDEX_Ctrl are all 0. The address and data fields are also cleared to 0.
- Hazard detection (need value 0/1/2) is evaluated only when cnt==0 and ID_Valid:
  - Load-use: IDEX_MemRead, IDEX_RegWrAddr!=0, and either IDEX_RegWrAddr==ID_Rs, or IDEX_RegWrAddr==ID_Rt with ID_UsesRt → need=1. A store whose only match is on rt → no stall (SAL forwarding handles it).
  - jr/jalr (OpCode 0, Funct 001000/001001) reading a load result:
    - IDEX_MemRead and IDEX_RegWrAddr==ID_Rs!=0 → need=2.
    - Otherwise, EXMEM_MemRead and EXMEM_RegWrAddr==ID_Rs!=0 → need=1.
  - The largest applicable need wins.
- Counter cnt (2 bits), states RUN (cnt=0) and STALL (cnt>0).
- Stall_Front = Stall_In | (cnt!=0) | (need!=0).
- Priority per edge: reset > Flush > Stall_In > hazard > normal.
  - Flush: load a bubble, cnt←0, whatever Stall_In is.
  - Stall_In (no Flush): all registers hold, cnt holds, Bubble_Cnt holds.
  - cnt!=0: load a bubble, cnt←cnt−1, Bubble_Cnt+1.
  - need!=0: load a bubble, cnt←need−1, Bubble_Cnt+1.
  - Normal: capture all ID_* fields. IDEX_Valid←ID_Valid.
- Latency: 1 cycle ID→IDEX. A load-use costs 1 bubble; jr directly after a load costs 2 bubbles; jr one slot after a load costs 1 bubble.
- Bubble_Cnt saturates at 2^32−1.
- Reset mid-stall: cnt cleared; the next cycle is RUN.

Decomposition:
- Shared package/header holds:
  - FUNCT_JR=6'b001000, FUNCT_JALR=6'b001001, OP_RTYPE=6'b0
  - MemtoReg encodings (00 ALU, 01 mem, 10 link)
  - DATA_W and CTRL_W defaults
- One combinational sub-module, load_use_detect, computes need[1:0] from the ID/IDEX/EXMEM fields. The register, counter and priority logic stay in idex_stage_reg.

Test Plan:
1. lw $8 in IDEX, ID=add $9,$8,$2 → Stall_Front=1 for 1 cycle; IDEX holds 1 bubble, then the add; Bubble_Cnt=1.
2. lw $8 in IDEX, ID=sw $8,0($3) (rt match only) → no stall; sw captured next edge.
3. lw $31 in IDEX, ID=jr $31 → 2 bubbles, Stall_Front high for 2 cycles; jr captured on the 3rd edge; Bubble_Cnt=2.
4. EXMEM lw $4, ID=jalr $4 → 1 bubble. Then lw $4 in IDEX with ID=add $5,$0,$0 → no stall.
5. Flush asserted in the 1st bubble cycle of scenario 3 → IDEX bubble, cnt=0, Stall_Front=0 next cycle; Stall_In=1 for 3 cycles mid-normal flow → IDEX_* unchanged, Bubble_Cnt unchanged.
6. reset during cnt=1 → all IDEX_* =0 and Bubble_Cnt=0 after the edge; a valid ID instruction is captured on the following edge.
